// File: rtl/mult_arb_pkg.sv
// Shared types and seven-segment constants for the shared-multiplier arbiter.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_9     = 7'h10;

endpackage

// File: rtl/seg7_decode.sv
// Combinational product-to-segment decode; only products of two 2-bit
// operands are given glyphs, every other code shows a blank digit.
module seg7_decode
    import mult_arb_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd6:    seg = SEG_6;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one 2x2 multiplier and one seven-segment digit.
// Define MULT_ARB_PERSIST_EN to keep the last product on the display after HOLD.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [2*N_REQ-1:0]         req_a,
    input  logic [2*N_REQ-1:0]         req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic [3:0]                 prod,
    output logic                       prod_valid,
    output logic [$clog2(N_REQ)-1:0]   prod_id,
    output logic [6:0]                 seg
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, grant_id, winner, cand;
    logic              found;
    logic [CNT_W-1:0]  hold_cnt;
    logic [2*N_REQ-1:0] a_shift, b_shift;
    logic [1:0]        op_a, op_b;
    logic [3:0]        prod_calc;
    logic              xfer;
    logic [6:0]        seg_dec;

    // First requesting index at or above rr_ptr, wrapping around
    always_comb begin
        winner = rr_ptr;
        cand   = '0;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign a_shift   = req_a >> {grant_id, 1'b0};
    assign b_shift   = req_b >> {grant_id, 1'b0};
    assign op_a      = a_shift[1:0];
    assign op_b      = b_shift[1:0];
    assign prod_calc = {2'b00, op_a} * {2'b00, op_b};
    assign xfer      = (state == CAPTURE) && req_valid[grant_id];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE:    if (found) state_nxt = CAPTURE;
            CAPTURE: begin
                req_ready[grant_id] = req_valid[grant_id];
                state_nxt = xfer ? HOLD : IDLE;
            end
            HOLD:    if (hold_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, pointer, counter and product registers; a dropped valid in
    // CAPTURE leaves product and pointer untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            prod     <= '0;
            prod_id  <= '0;
        end else begin
            if (state == IDLE && found) grant_id <= winner;
            if (xfer) begin
                prod     <= prod_calc;
                prod_id  <= grant_id;
                rr_ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                hold_cnt <= HOLD_LOAD;
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    assign prod_valid = (state == HOLD);

    seg7_decode u_dec (
        .code (prod),
        .seg  (seg_dec)
    );

`ifdef MULT_ARB_PERSIST_EN
    logic shown;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       shown <= 1'b0;
        else if (xfer) shown <= 1'b1;
    end

    assign seg = shown ? seg_dec : SEG_BLANK;
`else
    assign seg = prod_valid ? seg_dec : SEG_BLANK;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: stimulus queues expected products,
// a negedge monitor pops and compares each presented product.
module tb_mult_share_arbiter;
    import mult_arb_pkg::*;

    localparam int N = 4;
    localparam int H = 8;
`ifdef MULT_ARB_PERSIST_EN
    localparam bit PERSIST = 1'b1;
`else
    localparam bit PERSIST = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [2*N-1:0] req_a, req_b;
    logic [N-1:0]   req_ready;
    logic [3:0]     prod;
    logic           prod_valid;
    logic [1:0]     prod_id;
    logic [6:0]     seg;

    always #5 clk = ~clk;

    mult_share_arbiter #(.N_REQ(N), .HOLD_CYCLES(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_id    (prod_id),
        .seg        (seg)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] prod;
        logic [6:0] seg;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   spacing_expect = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // One clock; any handshake completed on this edge drops that requester's valid
    task automatic tick();
        logic [N-1:0] x;
        @(negedge clk);
        x = req_ready & req_valid;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~x;
    endtask

    task automatic request(input int i, input logic [1:0] a, input logic [1:0] b,
                           input logic [3:0] p, input logic [6:0] s);
        exp_t e;
        req_a[2*i +: 2] = a;
        req_b[2*i +: 2] = b;
        req_valid[i]    = 1'b1;
        e.id = 2'(i);
        e.prod = p;
        e.seg = s;
        expq.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((expq.size() != 0 || prod_valid || req_valid != '0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 32'd1);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Monitor
    initial begin
        logic       prev_pv = 1'b0;
        int         hold_len = 0;
        int         cyc = 0;
        int         last_rdy = 0;
        bit         have_last = 1'b0;
        logic [6:0] last_seg = SEG_BLANK;
        exp_t       e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_pv   = 1'b0;
                have_last = 1'b0;
                hold_len  = 0;
            end else begin
                if (req_ready != '0) begin
                    if (spacing_expect != 0 && have_last)
                        check("rr_spacing", 32'(cyc - last_rdy), 32'(spacing_expect));
                    last_rdy  = cyc;
                    have_last = (spacing_expect != 0);
                end
                if (prod_valid && !prev_pv) begin
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_prod: got id %0d prod %0d, required none", prod_id, prod);
                    end else begin
                        e = expq.pop_front();
                        check("prod", 32'(prod), 32'(e.prod));
                        check("prod_id", 32'(prod_id), 32'(e.id));
                        check("seg", 32'(seg), 32'(e.seg));
                        last_seg = e.seg;
                    end
                    hold_len = 1;
                end else if (prod_valid) begin
                    hold_len++;
                end
                if (!prod_valid && prev_pv) begin
                    check("hold_len", 32'(hold_len), 32'(H));
                    check("seg_after_hold", 32'(seg), 32'(PERSIST ? last_seg : SEG_BLANK));
                end
                prev_pv = prod_valid;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        int n;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_prod", 32'(prod), 32'd0);
        check("rst_prod_valid", 32'(prod_valid), 32'd0);
        check("rst_prod_id", 32'(prod_id), 32'd0);
        check("rst_seg", 32'(seg), 32'h7F);
        rst = 1'b0;
        tick();

        // single request
        request(2, 2'd3, 2'd3, 4'd9, 7'h10);
        tick();
        check("single_ready", 32'(req_ready), 32'b0100);
        wait_done(40);

        // fairness from reset: grants 0,1,2,3 spaced H+2 apart
        do_reset();
        spacing_expect = H + 2;
        request(0, 2'd1, 2'd1, 4'd1, 7'h79);
        request(1, 2'd2, 2'd1, 4'd2, 7'h24);
        request(2, 2'd2, 2'd2, 4'd4, 7'h19);
        request(3, 2'd3, 2'd1, 4'd3, 7'h30);
        wait_done(80);
        spacing_expect = 0;

        // wrap: pointer is back at 0 after requester 3
        request(0, 2'd3, 2'd2, 4'd6, 7'h02);
        request(3, 2'd1, 2'd0, 4'd0, 7'h40);
        wait_done(60);

        // dropped valid in CAPTURE
        req_a[3:2] = 2'd1;
        req_b[3:2] = 2'd1;
        req_valid[1] = 1'b1;
        tick();
        check("drop_ready_before", 32'(req_ready), 32'b0010);
        req_valid[1] = 1'b0;
        #1;
        check("drop_ready_after", 32'(req_ready), 32'd0);
        tick();
        check("drop_prod_valid", 32'(prod_valid), 32'd0);
        check("drop_prod", 32'(prod), 32'd0);
        check("drop_state_idle", 32'(dut.state), 32'(IDLE));
        // pointer still 0: requester 1 must win over 3
        request(1, 2'd2, 2'd2, 4'd4, 7'h19);
        request(3, 2'd1, 2'd1, 4'd1, 7'h79);
        wait_done(60);

        // asynchronous reset during HOLD
        request(2, 2'd2, 2'd3, 4'd6, 7'h02);
        n = 0;
        while (!prod_valid && n < 10) begin
            tick();
            n++;
        end
        check("mid_hold_reached", 32'(prod_valid), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("async_seg", 32'(seg), 32'h7F);
        check("async_prod_valid", 32'(prod_valid), 32'd0);
        check("async_prod", 32'(prod), 32'd0);
        check("async_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        request(0, 2'd1, 2'd2, 4'd2, 7'h24);
        request(3, 2'd3, 2'd3, 4'd9, 7'h10);
        wait_done(60);

        check("queue_empty", 32'(expq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
